// File: rtl/mcm_pkg.sv
// Shared definitions for the streaming multiple-constant multiplier.
// Contents:
//   slice_w     - per-channel result width (data width + constant width)
//   mcm_state_e - constant-reload FSM states
//   pack_consts - packs the constant bank into one wide multiplier operand
package mcm_pkg;

    // Upper bound on NUM_CONST*slice_w() supported by pack_consts.
    localparam int unsigned PACK_MAX_W = 512;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        SWAP  = 2'd2
    } mcm_state_e;

    function automatic int unsigned slice_w(input int unsigned data_w,
                                            input int unsigned const_w);
        return data_w + const_w;
    endfunction

    // A = sum over k of C_k << (k*s); constant k sits at bank[k*const_w +: const_w].
    function automatic logic [PACK_MAX_W-1:0] pack_consts(
        input logic [PACK_MAX_W-1:0] bank,
        input int unsigned           num_const,
        input int unsigned           const_w,
        input int unsigned           s
    );
        logic [PACK_MAX_W-1:0] a;
        logic [PACK_MAX_W-1:0] mask;
        a    = '0;
        mask = (PACK_MAX_W'(1) << const_w) - PACK_MAX_W'(1);
        for (int unsigned k = 0; k < num_const; k++) begin
            a = a | (((bank >> (k * const_w)) & mask) << (k * s));
        end
        return a;
    endfunction

endpackage

// File: rtl/mcm_field_extract.sv
// Splits the packed product P = X*A into per-channel results.
// Field k>0 is corrected by adding the sign bit of the lower fields, which is
// the borrow left behind when the lower partial sum is negative.
// Ports:
//   p        in  NUM_CONST*S  packed product
//   fields_c out NUM_CONST*S  channel k = X*C_k at [k*S +: S] (combinational)
module mcm_field_extract
    import mcm_pkg::*;
#(
    parameter int unsigned S         = 12,
    parameter int unsigned NUM_CONST = 2
) (
    input  logic [NUM_CONST*S-1:0] p,
    output logic [NUM_CONST*S-1:0] fields_c
);

    // Borrow-corrected slicing.
    always_comb begin
        fields_c        = '0;
        fields_c[0 +: S] = p[0 +: S];
        for (int unsigned k = 1; k < NUM_CONST; k++) begin
            fields_c[k*S +: S] = p[k*S +: S] + S'(p[k*S-1]);
        end
    end

endmodule

// File: rtl/mcm_stream_pack.sv
// Streaming multiple-constant multiplier: each signed sample X is multiplied
// by NUM_CONST unsigned runtime-reloadable constants using one packed wide
// multiply, then split into per-channel signed results.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     sample handshake, in_data = signed X
//   out_valid/out_ready   result handshake, out_data channel k at [k*S +: S]
//   cfg_we/cfg_idx/cfg_data  shadow constant write
//   cfg_commit            request shadow->active copy; cfg_busy while reloading
module mcm_stream_pack
    import mcm_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned NUM_CONST = 2,
    parameter int unsigned CONST_W   = 4,
    parameter logic [NUM_CONST*CONST_W-1:0] INIT_CONSTS = {4'd9, 4'd11}
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        in_valid,
    output logic                                        in_ready,
    input  logic [DATA_W-1:0]                           in_data,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic [NUM_CONST*(DATA_W+CONST_W)-1:0]       out_data,
    input  logic                                        cfg_we,
    input  logic [((NUM_CONST > 1) ? $clog2(NUM_CONST) : 1)-1:0] cfg_idx,
    input  logic [CONST_W-1:0]                          cfg_data,
    input  logic                                        cfg_commit,
    output logic                                        cfg_busy
);

    localparam int unsigned S      = slice_w(DATA_W, CONST_W);
    localparam int unsigned PW     = NUM_CONST * S;
    localparam int unsigned BANK_W = NUM_CONST * CONST_W;

    mcm_state_e state_q, state_d;

    logic [BANK_W-1:0]        shadow_q;
    logic [BANK_W-1:0]        active_q;
    logic                     v1_q;
    logic                     v2_q;
    logic signed [DATA_W-1:0] x1_q;
    logic [PW-1:0]            p2_q;

    logic                     adv_c;
    logic                     accept_c;
    logic [PACK_MAX_W-1:0]    a_full_c;
    logic [PW-1:0]            a_c;
    logic [PW-1:0]            x_ext_c;
    logic [PW-1:0]            p_c;
    logic [PW-1:0]            fields_c;
    logic                     unused_pack_hi;

    // Whole pipeline advances together; a stalled output freezes every stage.
    assign adv_c    = !out_valid || out_ready;
    assign in_ready = adv_c && (state_q == RUN);
    assign accept_c = in_valid && in_ready;

    // Packed multiply: sign-extending X to PW bits makes the modulo-2^PW
    // unsigned product equal to the signed x unsigned product.
    assign a_full_c       = pack_consts(PACK_MAX_W'(active_q), NUM_CONST, CONST_W, S);
    assign a_c            = a_full_c[PW-1:0];
    assign unused_pack_hi = ^a_full_c[PACK_MAX_W-1:PW];
    assign x_ext_c        = PW'(x1_q);
    assign p_c            = x_ext_c * a_c;

    mcm_field_extract #(
        .S         (S),
        .NUM_CONST (NUM_CONST)
    ) u_extract (
        .p        (p2_q),
        .fields_c (fields_c)
    );

    // Three-stage datapath: S1 = X, S2 = P, S3 = extracted fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            out_valid <= 1'b0;
            x1_q      <= '0;
            p2_q      <= '0;
            out_data  <= '0;
        end else if (adv_c) begin
            v1_q      <= accept_c;
            v2_q      <= v1_q;
            out_valid <= v2_q;
            if (accept_c) begin
                x1_q <= in_data;
            end
            if (v1_q) begin
                p2_q <= p_c;
            end
            if (v2_q) begin
                out_data <= fields_c;
            end
        end
    end

    // Constant banks; the active bank only changes in SWAP, when the pipeline is empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= INIT_CONSTS;
            active_q <= INIT_CONSTS;
        end else begin
            if (cfg_we && (32'(cfg_idx) < NUM_CONST)) begin
                shadow_q[32'(cfg_idx) * CONST_W +: CONST_W] <= cfg_data;
            end
            if (state_q == SWAP) begin
                active_q <= shadow_q;
            end
        end
    end

    // Reload FSM state register; busy is registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN;
            cfg_busy <= 1'b0;
        end else begin
            state_q  <= state_d;
            cfg_busy <= (state_d != RUN);
        end
    end

    // Reload FSM next state: drain the pipeline, then swap banks for one cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:     if (cfg_commit) state_d = DRAIN;
            DRAIN:   if (!v1_q && !v2_q && !out_valid) state_d = SWAP;
            SWAP:    state_d = RUN;
            default: state_d = RUN;
        endcase
    end

endmodule

// File: tb/tb_mcm_stream_pack.sv
// Scoreboard bench for mcm_stream_pack: a default instance (8-bit data,
// constants 9/11) exercised with directed sequences, and a 12/4/6 instance
// exercised with random samples, constants and backpressure.
module tb_mcm_stream_pack;

    logic clk;
    logic rst_n;

    // Default instance: DATA_W=8, NUM_CONST=2, CONST_W=4, S=12.
    logic        in_valid0, in_ready0, out_valid0, out_ready0;
    logic [7:0]  in_data0;
    logic [23:0] out_data0;
    logic        cfg_we0, cfg_commit0, cfg_busy0;
    logic [0:0]  cfg_idx0;
    logic [3:0]  cfg_data0;

    // Wide instance: DATA_W=12, NUM_CONST=4, CONST_W=6, S=18.
    logic        in_valid1, in_ready1, out_valid1, out_ready1;
    logic [11:0] in_data1;
    logic [71:0] out_data1;
    logic        cfg_we1, cfg_commit1, cfg_busy1;
    logic [1:0]  cfg_idx1;
    logic [5:0]  cfg_data1;

    int checks = 0;
    int errors = 0;

    // Reference model state: constants currently in force, per channel.
    int act0[4];
    int act1[4];
    int sh1[4];

    logic [127:0] q0[$];
    int           t0[$];
    logic [127:0] q1[$];
    int           ncyc = 0;
    logic         lat_chk = 1'b0;

    mcm_stream_pack u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
        .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
        .cfg_we(cfg_we0), .cfg_idx(cfg_idx0), .cfg_data(cfg_data0),
        .cfg_commit(cfg_commit0), .cfg_busy(cfg_busy0)
    );

    mcm_stream_pack #(
        .DATA_W(12), .NUM_CONST(4), .CONST_W(6),
        .INIT_CONSTS({6'd63, 6'd1, 6'd0, 6'd37})
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
        .cfg_we(cfg_we1), .cfg_idx(cfg_idx1), .cfg_data(cfg_data1),
        .cfg_commit(cfg_commit1), .cfg_busy(cfg_busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected packed output: each channel is the exact product X*C_k in s bits.
    function automatic logic [127:0] mcm_ref(input longint x, input int c[4],
                                             input int nc, input int s);
        logic [127:0] r;
        logic [127:0] f;
        longint       pr;
        r = '0;
        for (int k = 0; k < nc; k++) begin
            pr = x * longint'(c[k]);
            f  = 128'(pr) & ((128'(1) << s) - 128'(1));
            r  = r | (f << (k * s));
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send0(input int x);
        in_valid0 = 1'b1;
        in_data0  = 8'(x);
        tick();
        in_valid0 = 1'b0;
    endtask

    task automatic wait_drain0(input string nm);
        int n = 0;
        while (q0.size() != 0 && n < 60) begin
            tick();
            n++;
        end
        chk(nm, 128'(q0.size()), 128'(0));
    endtask

    task automatic wait_idle0();
        int n = 0;
        while (cfg_busy0 && n < 20) begin
            tick();
            n++;
        end
        chk("busy0_timeout", 128'(cfg_busy0), 128'(0));
    endtask

    task automatic drive_stream1();
        in_valid1  = ($urandom_range(0, 1) == 1);
        in_data1   = ($urandom_range(0, 7) == 0) ? 12'h800 : 12'($urandom);
        out_ready1 = ($urandom_range(0, 3) != 0);
    endtask

    // Monitor, default instance: push on input transfer, pop/compare on output transfer.
    always @(negedge clk) begin : mon0
        logic [127:0] e;
        int           ta;
        ncyc++;
        if (rst_n) begin
            if (in_valid0 && in_ready0) begin
                q0.push_back(mcm_ref(longint'($signed(in_data0)), act0, 2, 12));
                t0.push_back(ncyc);
            end
            if (out_valid0 && out_ready0) begin
                if (q0.size() == 0) begin
                    chk("out0_spurious", 128'(1), 128'(0));
                end else begin
                    e  = q0.pop_front();
                    ta = t0.pop_front();
                    chk("out0_data", 128'(out_data0), e);
                    if (lat_chk) chk("out0_latency", 128'(ncyc - ta), 128'(3));
                end
            end
        end
    end

    // Monitor, wide instance.
    always @(negedge clk) begin : mon1
        logic [127:0] e;
        if (rst_n) begin
            if (in_valid1 && in_ready1) begin
                q1.push_back(mcm_ref(longint'($signed(in_data1)), act1, 4, 18));
            end
            if (out_valid1 && out_ready1) begin
                if (q1.size() == 0) begin
                    chk("out1_spurious", 128'(1), 128'(0));
                end else begin
                    e = q1.pop_front();
                    chk("out1_data", 128'(out_data1), e);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [23:0] snap;
        int          busy_n;
        int          n;
        int          val;

        in_valid0 = 0; in_data0 = '0; out_ready0 = 1; cfg_we0 = 0;
        cfg_idx0 = '0; cfg_data0 = '0; cfg_commit0 = 0;
        in_valid1 = 0; in_data1 = '0; out_ready1 = 1; cfg_we1 = 0;
        cfg_idx1 = '0; cfg_data1 = '0; cfg_commit1 = 0;
        act0 = '{11, 9, 0, 0};
        act1 = '{37, 0, 1, 63};
        sh1  = act1;
        snap = '0;

        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 128'(out_valid0), 128'(0));
        chk("rst_out_data",  128'(out_data0),  128'(0));
        chk("rst_in_ready",  128'(in_ready0),  128'(1));
        chk("rst_busy",      128'(cfg_busy0),  128'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Extremes back-to-back, fixed latency 3.
        lat_chk = 1'b1;
        send0(-128); send0(127); send0(-1); send0(0);
        wait_drain0("t1_drain");
        lat_chk = 1'b0;

        // Backpressure with continuous input.
        out_ready0 = 1'b0;
        in_valid0  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data0 = 8'($urandom);
            tick();
            if (i == 2) snap = out_data0;
        end
        chk("bp_inflight",  128'(q0.size()),  128'(3));
        chk("bp_in_ready",  128'(in_ready0),  128'(0));
        chk("bp_out_valid", 128'(out_valid0), 128'(1));
        chk("bp_stable",    128'(out_data0),  128'(snap));
        in_valid0  = 1'b0;
        out_ready0 = 1'b1;
        wait_drain0("bp_drain");

        // Reload with two samples in flight.
        cfg_we0 = 1; cfg_idx0 = 1'b0; cfg_data0 = 4'd15; tick();
        cfg_idx0 = 1'b1; cfg_data0 = 4'd0; tick();
        cfg_we0 = 0;
        send0(20); send0(-7);
        cfg_commit0 = 1; tick(); cfg_commit0 = 0;
        busy_n = 0;
        while (cfg_busy0 && busy_n < 20) begin
            chk("drain_in_ready", 128'(in_ready0), 128'(0));
            busy_n++;
            tick();
        end
        chk("reload_busy_cycles", 128'(busy_n), 128'(4));
        act0 = '{15, 0, 0, 0};
        send0(5); send0(-3);
        wait_drain0("reload_drain");

        // Write in commit cycle applied; second commit ignored; SWAP-cycle write deferred.
        cfg_we0 = 1; cfg_idx0 = 1'b0; cfg_data0 = 4'd3; tick();
        cfg_idx0 = 1'b1; cfg_data0 = 4'd7; cfg_commit0 = 1; tick();
        cfg_we0 = 0;
        chk("sim_busy_drain", 128'(cfg_busy0), 128'(1));
        tick();
        cfg_commit0 = 0;
        chk("sim_busy_swap", 128'(cfg_busy0), 128'(1));
        cfg_we0 = 1; cfg_idx0 = 1'b0; cfg_data0 = 4'd12; tick();
        cfg_we0 = 0;
        chk("sim_busy_done", 128'(cfg_busy0), 128'(0));
        tick();
        chk("sim_second_commit", 128'(cfg_busy0), 128'(0));
        act0 = '{3, 7, 0, 0};
        send0(-100); send0(55);
        wait_drain0("sim_drain");
        cfg_commit0 = 1; tick(); cfg_commit0 = 0;
        wait_idle0();
        act0 = '{12, 7, 0, 0};
        send0(-128); send0(99);
        wait_drain0("sim_drain2");

        // Reset mid-stream.
        in_valid0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data0 = 8'($urandom);
            tick();
        end
        rst_n = 1'b0; in_valid0 = 1'b0;
        #1;
        chk("mrst_out_valid", 128'(out_valid0), 128'(0));
        chk("mrst_out_data",  128'(out_data0),  128'(0));
        chk("mrst_in_ready",  128'(in_ready0),  128'(1));
        q0.delete(); t0.delete();
        act0 = '{11, 9, 0, 0};
        tick(); rst_n = 1'b1; tick();
        send0(-128); send0(127);
        wait_drain0("mrst_drain");

        // Reset mid-DRAIN: pending commit and shadow write discarded.
        cfg_we0 = 1; cfg_idx0 = 1'b0; cfg_data0 = 4'd1; tick();
        cfg_we0 = 0;
        send0(10); send0(11);
        cfg_commit0 = 1; tick(); cfg_commit0 = 0;
        chk("drst_busy_before", 128'(cfg_busy0), 128'(1));
        rst_n = 1'b0;
        #1;
        chk("drst_out_valid", 128'(out_valid0), 128'(0));
        chk("drst_out_data",  128'(out_data0),  128'(0));
        chk("drst_busy",      128'(cfg_busy0),  128'(0));
        chk("drst_in_ready",  128'(in_ready0),  128'(1));
        q0.delete(); t0.delete();
        tick(); rst_n = 1'b1; tick();
        cfg_commit0 = 1; tick(); cfg_commit0 = 0;
        wait_idle0();
        send0(-1); send0(64);
        wait_drain0("drst_drain");

        // Wide instance: random constants, samples and backpressure.
        for (int r = 0; r < 6; r++) begin
            if (r > 0) begin
                for (int k = 0; k < 4; k++) begin
                    val = ($urandom_range(0, 3) == 0) ? 63 : int'($urandom_range(0, 63));
                    cfg_we1 = 1; cfg_idx1 = 2'(k); cfg_data1 = 6'(val);
                    sh1[k] = val;
                    drive_stream1();
                    tick();
                end
                cfg_we1 = 0; cfg_commit1 = 1;
                drive_stream1();
                tick();
                cfg_commit1 = 0;
                act1 = sh1;
                n = 0;
                while (cfg_busy1 && n < 40) begin
                    drive_stream1();
                    tick();
                    n++;
                end
                chk("p_busy_timeout", 128'(cfg_busy1), 128'(0));
            end
            repeat (40) begin
                drive_stream1();
                tick();
            end
        end
        in_valid1 = 0; out_ready1 = 1;
        n = 0;
        while (q1.size() != 0 && n < 60) begin
            tick();
            n++;
        end
        chk("p_drain", 128'(q1.size()), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
